// File: rtl/imem_axil_loader.sv
// imem_axil_loader
//   AXI4-Lite slave that loads program images into the instruction memory
//   through its write port. It also owns the core-hold control bit and a
//   saturating counter of successfully written words.
//
//   Address map (byte addresses, bits [1:0] ignored):
//     0x000 .. 4*IMEM_WORDS-4  IMEM window (write-only; reads give SLVERR)
//     0x400                    CTRL  bit0 cpu_hold (R/W), bit1 count_clear (W1, reads 0)
//     0x404                    COUNT bits[15:0] accepted IMEM words (read-only)
//     anything else            DECERR
//
//   Handshakes: a transfer on any AXI channel happens on the rising clk edge
//   where both valid and ready are high. The slave holds each valid and its
//   payload stable until ready is seen, and never waits on the master's
//   valid before raising its own ready.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   s_aw*/s_w*/s_b*            AXI4-Lite write address / data / response
//   s_ar*/s_r*                 AXI4-Lite read address / data
//   imem_write_en/addr/data    one-cycle write strobe, word index and data to imem
//   cpu_hold                   1 holds the CPU core in reset
module imem_axil_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int IMEM_WORDS = 256,
  parameter bit HOLD_RST   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [31:0]           s_wdata,
  input  logic [3:0]            s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [31:0]           s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic                  imem_write_en,
  output logic [7:0]            imem_write_addr,
  output logic [31:0]           imem_write_data,
  output logic                  cpu_hold
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam logic [IDX_W-1:0] IMEM_LIM  = IDX_W'(IMEM_WORDS);
  localparam logic [IDX_W-1:0] CTRL_IDX  = IDX_W'(32'h100);
  localparam logic [IDX_W-1:0] COUNT_IDX = IDX_W'(32'h101);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {W_COLLECT, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic                  aw_held;
  logic [31:0]           w_data_q;
  logic [3:0]            w_strb_q;
  logic                  w_held;
  logic [15:0]           count;

  logic                  aw_fire, w_fire;
  logic [ADDR_WIDTH-1:0] addr_eff;
  logic [31:0]           data_eff;
  logic [3:0]            strb_eff;
  logic [IDX_W-1:0]      widx, ridx;
  logic                  do_access, wr_imem, wr_ctrl, wr_full;
  logic                  count_inc, count_clr;
  logic                  unused_addr_lsbs;

  // The access is decoded on the edge where the second of AW/W arrives, so
  // the payload comes from the capture register if already held, otherwise
  // straight from the bus.
  always_comb begin
    aw_fire   = s_awvalid & s_awready;
    w_fire    = s_wvalid & s_wready;
    addr_eff  = aw_held ? aw_addr_q : s_awaddr;
    data_eff  = w_held ? w_data_q : s_wdata;
    strb_eff  = w_held ? w_strb_q : s_wstrb;
    do_access = (w_state == W_COLLECT) & (aw_held | aw_fire) & (w_held | w_fire);
    widx      = addr_eff[ADDR_WIDTH-1:2];
    ridx      = s_araddr[ADDR_WIDTH-1:2];
    wr_imem   = widx < IMEM_LIM;
    wr_ctrl   = widx == CTRL_IDX;
    wr_full   = strb_eff == 4'hF;
    count_inc = do_access & wr_imem & wr_full;
    count_clr = do_access & wr_ctrl & strb_eff[0] & data_eff[1];
  end

  assign unused_addr_lsbs = ^{addr_eff[1:0], s_araddr[1:0]};

  // Write channel FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state         <= W_COLLECT;
      s_awready       <= 1'b0;
      s_wready        <= 1'b0;
      s_bvalid        <= 1'b0;
      s_bresp         <= RESP_OKAY;
      aw_held         <= 1'b0;
      w_held          <= 1'b0;
      aw_addr_q       <= '0;
      w_data_q        <= '0;
      w_strb_q        <= '0;
      imem_write_en   <= 1'b0;
      imem_write_addr <= '0;
      imem_write_data <= '0;
      cpu_hold        <= HOLD_RST;
    end else begin
      imem_write_en <= 1'b0;
      case (w_state)
        W_COLLECT: begin
          if (do_access) begin
            w_state   <= W_RESP;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            s_bvalid  <= 1'b1;
            if (wr_imem) begin
              if (wr_full) begin
                imem_write_en   <= 1'b1;
                imem_write_addr <= addr_eff[9:2];
                imem_write_data <= data_eff;
                s_bresp         <= RESP_OKAY;
              end else begin
                s_bresp <= RESP_SLVERR;
              end
            end else if (wr_ctrl) begin
              s_bresp <= RESP_OKAY;
              if (strb_eff[0]) cpu_hold <= data_eff[0];
            end else begin
              s_bresp <= RESP_DECERR;
            end
          end else begin
            if (aw_fire) begin
              aw_addr_q <= s_awaddr;
              aw_held   <= 1'b1;
            end
            if (w_fire) begin
              w_data_q <= s_wdata;
              w_strb_q <= s_wstrb;
              w_held   <= 1'b1;
            end
            s_awready <= ~(aw_held | aw_fire);
            s_wready  <= ~(w_held | w_fire);
          end
        end
        W_RESP: begin
          if (s_bready) begin
            w_state   <= W_COLLECT;
            s_bvalid  <= 1'b0;
            s_awready <= 1'b1;
            s_wready  <= 1'b1;
          end
        end
        default: w_state <= W_COLLECT;
      endcase
    end
  end

  // Accepted-word counter; a clear beats a simultaneous increment.
  always_ff @(posedge clk) begin
    if (rst)                                count <= '0;
    else if (count_clr)                     count <= '0;
    else if (count_inc && count != 16'hFFFF) count <= count + 16'd1;
  end

  // Read channel FSM. Registers are sampled before this edge's updates, so a
  // read coinciding with a write sees the old CTRL/COUNT contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= R_IDLE;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      s_rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_arvalid && s_arready) begin
            r_state   <= R_DATA;
            s_arready <= 1'b0;
            s_rvalid  <= 1'b1;
            if (ridx < IMEM_LIM) begin
              s_rdata <= '0;
              s_rresp <= RESP_SLVERR;
            end else if (ridx == CTRL_IDX) begin
              s_rdata <= {31'd0, cpu_hold};
              s_rresp <= RESP_OKAY;
            end else if (ridx == COUNT_IDX) begin
              s_rdata <= {16'd0, count};
              s_rresp <= RESP_OKAY;
            end else begin
              s_rdata <= '0;
              s_rresp <= RESP_DECERR;
            end
          end else begin
            s_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_rready) begin
            r_state   <= R_IDLE;
            s_rvalid  <= 1'b0;
            s_arready <= 1'b1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
